// File: rtl/loader_pkg.sv
// Shared definitions for the instruction RAM loader: FSM encoding and
// default geometry of the instruction RAM.
package loader_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DEPTH_DEF  = 512;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/loader_byte_pack.sv
// Byte-to-word assembler: latches a high byte and presents it concatenated
// with the current byte, so the low byte is used straight off the stream.
module loader_byte_pack (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cap_hi_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] word_o
);

    logic [7:0] hi_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)        hi_q <= '0;
        else if (cap_hi_i) hi_q <= byte_i;
    end

    assign word_o = {hi_q, byte_i};

endmodule

// File: rtl/iram_loader.sv
// Streams a big-endian length header plus 16-bit words from a byte
// interface into instruction RAM, then releases the core.
module iram_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              iram_write_en,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [15:0]       iram_data,
    output logic              core_start,
    output logic              busy,
    output logic              len_err
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
    logic [15:0]       len_q, len_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              cap_hi;
    logic              accept;
    logic [15:0]       word;

    loader_byte_pack u_pack (
        .clock    (clock),
        .rst_n    (rst_n),
        .cap_hi_i (cap_hi),
        .byte_i   (byte_data),
        .word_o   (word)
    );

    assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                        (state_q == DATA_HI) || (state_q == DATA_LO);
    assign accept     = byte_valid && byte_ready;
    assign cnt_inc    = cnt_q + 1'b1;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cap_hi  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (load_req) begin
                    state_d = LEN_HI;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    cap_hi  = 1'b1;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    if (word == 16'd0 || word > 16'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        len_d   = word;
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    cap_hi  = 1'b1;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                // Address/data are registered here so the RAM sees them in
                // WRITE and they hold afterwards without extra muxing.
                if (accept) begin
                    addr_d  = cnt_q[ADDR_W-1:0];
                    data_d  = word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = cnt_inc;
                state_d = (16'(cnt_inc) == len_q) ? DONE : DATA_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    assign iram_write_en = (state_q == WRITE);
    assign iram_addr     = addr_q;
    assign iram_data     = data_q;
    assign core_start    = (state_q == DONE);
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign len_err       = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: expected RAM writes go into a scoreboard
// queue as bytes are driven and are checked as the DUT strobes them.
module tb_iram_loader;

    logic        clock;
    logic        rst_n;
    logic        load_req;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        iram_write_en;
    logic [8:0]  iram_addr;
    logic [15:0] iram_data;
    logic        core_start;
    logic        busy;
    logic        len_err;

    typedef struct packed {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_wr  = 0;

    iram_loader dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .load_req      (load_req),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .iram_write_en (iram_write_en),
        .iram_addr     (iram_addr),
        .iram_data     (iram_data),
        .core_start    (core_start),
        .busy          (busy),
        .len_err       (len_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe cycle must match the oldest expected write.
    always @(negedge clock) begin
        if (rst_n && iram_write_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(iram_addr), 32'h1ff00000);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(iram_addr), 32'(e.a));
                chk("wr_data", 32'(iram_data), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t;
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        byte_valid = 1'b0;
        for (int i = 0; i < g; i++) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            tick();
            t++;
        end
        if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] a, input logic [15:0] d, input int max_gap);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        send_byte(d[15:8], max_gap);
        send_byte(d[7:0], max_gap);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!core_start && t < 100) begin
            tick();
            t++;
        end
        chk(tag, 32'(core_start), 32'd1);
    endtask

    initial begin
        int w0;
        rst_n      = 1'b0;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_write_en",   32'(iram_write_en), 32'd0);
        chk("rst_addr",       32'(iram_addr), 32'd0);
        chk("rst_data",       32'(iram_data), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_len_err",    32'(len_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic load: 00 02 12 34 AB CD
        do_load_req();
        chk("basic_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(9'd0, 16'h1234, 0);
        send_word(9'd1, 16'hABCD, 0);
        wait_done("basic_core_start");
        chk("basic_busy_done", 32'(busy), 32'd0);
        chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("basic_wr_count", 32'(n_wr), 32'd2);

        // Reload from DONE with gapped bytes: core_start drops on the next edge.
        do_load_req();
        chk("reload_core_start", 32'(core_start), 32'd0);
        chk("reload_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 3);
        send_byte(8'h03, 3);
        send_word(9'd0, 16'h5A01, 3);
        send_word(9'd1, 16'hC3F7, 3);
        send_word(9'd2, 16'h0080, 3);
        wait_done("bp_core_start");
        chk("bp_wr_count", 32'(n_wr), 32'd5);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Illegal length 0.
        do_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("len0_err", 32'(len_err), 32'd1);
        chk("len0_core_start", 32'(core_start), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_idle_ready", 32'(byte_ready), 32'd0);
        tick();
        tick();
        chk("len0_no_write", 32'(n_wr), 32'd5);

        // Illegal length 513.
        do_load_req();
        chk("len_err_cleared", 32'(len_err), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        chk("len513_err", 32'(len_err), 32'd1);
        chk("len513_core_start", 32'(core_start), 32'd0);
        chk("len513_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("len513_no_write", 32'(n_wr), 32'd5);

        // Full 512-word load, from IDLE after an error.
        do_load_req();
        chk("full_len_err_cleared", 32'(len_err), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 512; i++)
            send_word(9'(i), 16'((i * 16'h0137) ^ 16'hA5C3), 0);
        wait_done("full_core_start");
        chk("full_last_addr", 32'(iram_addr), 32'd511);
        for (int i = 0; i < 5; i++) tick();
        chk("full_wr_count", 32'(n_wr), 32'd517);
        chk("full_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("full_still_done", 32'(core_start), 32'd1);

        // Reset right after the low byte is accepted (DUT is in WRITE).
        do_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        chk("pre_rst_in_write", 32'(iram_write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_write_en", 32'(iram_write_en), 32'd0);
        chk("midrst_addr", 32'(iram_addr), 32'd0);
        chk("midrst_data", 32'(iram_data), 32'd0);
        chk("midrst_core_start", 32'(core_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
        chk("midrst_len_err", 32'(len_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        w0 = n_wr;
        do_load_req();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(9'd0, 16'h7E11, 1);
        wait_done("after_rst_core_start");
        chk("after_rst_wr_count", 32'(n_wr - w0), 32'd1);
        chk("after_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the instruction RAM address width.
REQ-002 SHALL have parameter DEPTH, default 512, meaning the maximum number of words loadable (2**ADDR_W).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port load_req, input, 1 bit: start-load request; sampled only in IDLE or DONE.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_data is valid.
REQ-007 SHALL have port byte_data, input, 8 bits: incoming byte stream.
REQ-008 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port iram_write_en, output, 1 bit: instruction RAM write strobe.
REQ-010 SHALL have port iram_addr, output, ADDR_W bits: instruction RAM write address.
REQ-011 SHALL have port iram_data, output, 16 bits: instruction RAM write data.
REQ-012 SHALL have port core_start, output, 1 bit: drives the core start input.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 SHALL have port len_err, output, 1 bit: the last load header was illegal.

Function
REQ-015 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE and DONE.
REQ-016 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both 1; byte_valid without byte_ready consumes nothing.
REQ-017 SHALL assert byte_ready only in LEN_HI, LEN_LO, DATA_HI and DATA_LO, and SHALL hold it at 0 otherwise.
REQ-018 SHALL move IDLE or DONE to LEN_HI on load_req=1, clearing core_start, len_err and the word counter on the same edge.
REQ-019 SHALL ignore load_req in every other state.
REQ-020 SHALL form the 16-bit length big-endian: the LEN_HI byte is bits 15:8 and the LEN_LO byte is bits 7:0.
REQ-021 SHALL treat a length of 0 or greater than DEPTH as illegal: it sets len_err=1, returns to IDLE, performs no write and leaves core_start at 0.
REQ-022 SHALL go to DATA_HI after a legal length.
REQ-023 SHALL go DATA_HI to DATA_LO to WRITE on byte acceptance, with the word formed as {hi byte, lo byte}.
REQ-024 SHALL assert iram_write_en for exactly one cycle in WRITE, with iram_addr equal to the word counter[ADDR_W-1:0] and iram_data equal to the assembled word.
REQ-025 SHALL perform the write on the cycle after the low byte is accepted, giving a peak rate of one word per 3 cycles.
REQ-026 SHALL use an ADDR_W+1 bit word counter, incremented in WRITE.
REQ-027 SHALL go to DONE after the increment if the counter equals the length, and to DATA_HI otherwise.
REQ-028 SHALL never wrap iram_addr within a load.
REQ-029 SHALL hold core_start=1 in DONE until the next load_req.
REQ-030 SHALL hold iram_addr and iram_data at their last values while iram_write_en=0.
REQ-031 SHALL drive busy=1 in every state except IDLE and DONE.

Reset
REQ-032 SHALL on rst_n=0 immediately force IDLE, counter 0, length 0, and byte_ready, iram_write_en, iram_addr, iram_data, core_start, busy and len_err all to 0.
REQ-033 SHALL abort a load on reset mid-load, leave core_start at 0 and suppress any pending write.

Structure
REQ-034 SHALL take the state enumeration, ADDR_W default and DEPTH default from a shared package, loader_pkg.
REQ-035 SHALL be a single FSM with counter; one natural sub-module, loader_byte_pack (the byte-to-word assembler), is permitted and not required.

Verification
REQ-036 SHALL test a basic load: load_req, then bytes 00 02 12 34 AB CD -> writes addr0=0x1234 and addr1=0xABCD, then core_start=1 and busy=0.
REQ-037 SHALL test backpressure: byte_valid gapped randomly, 3-word load -> exactly 3 writes with correct data and addresses 0, 1, 2.
REQ-038 SHALL test illegal lengths: 00 00 and separately 02 01 (513) -> len_err=1, no iram_write_en, core_start=0, back in IDLE.
REQ-039 SHALL test a full load: length 512 (02 00) -> last write at addr 511, DONE, no wrap to addr 0.
REQ-040 SHALL test reset mid-load: rst_n=0 after the DATA_LO byte is accepted -> no write, all outputs 0; a new load then succeeds.
REQ-041 SHALL test a reload: load_req in DONE -> core_start falls to 0 on the next edge, and a new image is written from addr 0.
